// File: rtl/vidscan.sv
// Scans a 320x200 8-bpp page out as 640x400@70Hz VGA via a double line buffer and 12-bit palette.
// Latency: colour, hs and vs appear 2 clocks after their counter position; vblank is immediate.
// Backpressure: none; memory reads are strobed with rd and data is expected exactly one clock later.
module vidscan (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        page,
   output logic [17:0] a,
   output logic        rd,
   input  logic [7:0]  i,
   input  logic        pal_we,
   input  logic [7:0]  pal_a,
   input  logic [11:0] pal_d,
   output logic [3:0]  r,
   output logic [3:0]  g,
   output logic [3:0]  b,
   output logic        hs,
   output logic        vs,
   output logic        vblank
);

   localparam logic [9:0] H_VIS   = 10'd640;
   localparam logic [9:0] H_SS    = 10'd656;
   localparam logic [9:0] H_SE    = 10'd752;
   localparam logic [9:0] H_LAST  = 10'd799;
   localparam logic [9:0] F_LEN   = 10'd320;
   localparam logic [8:0] V_VIS   = 9'd400;
   localparam logic [8:0] V_SS    = 9'd412;
   localparam logic [8:0] V_SE    = 9'd414;
   localparam logic [8:0] V_FLIM  = 9'd398;
   localparam logic [8:0] V_LAST  = 9'd448;

   // HOLD covers the first clock after reset release so that position (0,448)
   // is presented with its fetch strobe, instead of being skipped.
   typedef enum logic {ST_HOLD, ST_RUN} state_t;

   state_t      state, state_nx;
   logic [9:0]  x, x_nx;
   logic [8:0]  y, y_nx;
   logic        page_l, pg_nx;
   logic        fetch_nx;
   logic [7:0]  line_nx;
   logic [16:0] off_nx;

   logic [8:0]  fcol;
   logic        fbank;
   logic        wr_vld;
   logic [8:0]  wr_col;
   logic        wr_bank;
   logic [9:0]  wr_idx;

   logic        vis;
   logic [8:0]  rd_col;
   logic [9:0]  rd_idx;
   logic [7:0]  lb_q;
   logic        de1, hs1, vs1;

   logic [7:0]  lb  [0:639];
   logic [11:0] pal [0:255];

   // State and raster counter registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_HOLD;
         x     <= 10'd0;
         y     <= V_LAST;
      end else begin
         state <= state_nx;
         x     <= x_nx;
         y     <= y_nx;
      end
   end

   // Next raster position: hold at (0,448) for one clock after reset, then free-run.
   always_comb begin
      state_nx = ST_RUN;
      x_nx     = x;
      y_nx     = y;
      if (state == ST_RUN) begin
         if (x == H_LAST) begin
            x_nx = 10'd0;
            y_nx = (y == V_LAST) ? 9'd0 : y + 9'd1;
         end else begin
            x_nx = x + 10'd1;
         end
      end
   end

   // Fetch decision for the upcoming position; page is taken live only when entering (0,448).
   always_comb begin
      pg_nx = page_l;
      if (x_nx == 10'd0 && y_nx == V_LAST) pg_nx = page;
      fetch_nx = (x_nx < F_LEN) && ((y_nx == V_LAST) || (y_nx < V_FLIM && y_nx[0]));
      line_nx  = (y_nx == V_LAST) ? 8'd0 : y_nx[8:1] + 8'd1;
      off_nx   = 17'(line_nx) * 17'd320 + 17'(x_nx);
   end

   // Registered memory request plus the column/bank it will land in.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         page_l  <= 1'b0;
         rd      <= 1'b0;
         a       <= 18'd0;
         fcol    <= 9'd0;
         fbank   <= 1'b0;
         wr_vld  <= 1'b0;
         wr_col  <= 9'd0;
         wr_bank <= 1'b0;
      end else begin
         page_l  <= pg_nx;
         rd      <= fetch_nx;
         a       <= fetch_nx ? ({1'b0, pg_nx, 16'h0} + {1'b0, off_nx}) : 18'd0;
         fcol    <= x_nx[8:0];
         fbank   <= line_nx[0];
         wr_vld  <= rd;
         wr_col  <= fcol;
         wr_bank <= fbank;
      end
   end

   assign wr_idx = wr_bank ? (10'd320 + {1'b0, wr_col}) : {1'b0, wr_col};
   assign vis    = (x < H_VIS) && (y < V_VIS);
   assign rd_col = vis ? x[9:1] : 9'd0;
   assign rd_idx = y[1] ? (10'd320 + {1'b0, rd_col}) : {1'b0, rd_col};
   assign vblank = (y >= V_VIS);

   // Line buffer: write returning fetch data, read the pixel for stage 1.
   always_ff @(posedge clock) begin
      if (wr_vld) lb[wr_idx] <= i;
      lb_q <= lb[rd_idx];
   end

   // Palette RAM write port; lookups in the same clock see the previous contents.
   always_ff @(posedge clock) begin
      if (pal_we) pal[pal_a] <= pal_d;
   end

   // Two-stage pipe carrying display-enable and syncs alongside the pixel.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         de1       <= 1'b0;
         hs1       <= 1'b1;
         vs1       <= 1'b0;
         {r, g, b} <= 12'h000;
         hs        <= 1'b1;
         vs        <= 1'b0;
      end else begin
         de1       <= vis;
         hs1       <= !(x >= H_SS && x < H_SE);
         vs1       <= (y >= V_SS && y < V_SE);
         {r, g, b} <= de1 ? pal[lb_q] : 12'h000;
         hs        <= hs1;
         vs        <= vs1;
      end
   end

endmodule

// File: tb/tb_vidscan.sv
// Bench for vidscan: memory and palette models, a per-cycle output comparison against a raster model,
// plus literal spot checks for reset, fetch addressing, sync edges, pixel colours and palette collision.
// Runs two short post-reset windows rather than whole frames.
module tb_vidscan;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        page = 1'b0;
   logic [17:0] a;
   logic        rd;
   logic [7:0]  i = 8'h00;
   logic        pal_we = 1'b0;
   logic [7:0]  pal_a = 8'h00;
   logic [11:0] pal_d = 12'h000;
   logic [3:0]  r, g, b;
   logic        hs, vs, vblank;

   int          errors = 0;
   int          checks = 0;
   int          n = 0;
   bit          chk_en = 1'b0;
   int          mpage = 0;
   bit          pw_vld = 1'b0;
   int          pw_n = 0;
   logic [7:0]  pw_idx = 8'h00;
   logic [11:0] pw_val = 12'h000;
   bit          mr_pv = 1'b0;
   logic [17:0] mr_pa = 18'd0;

   logic [7:0]  mem  [0:262143];
   logic [11:0] mpal [0:255];

   vidscan dut (
      .clock(clock), .reset_n(reset_n), .page(page), .a(a), .rd(rd), .i(i),
      .pal_we(pal_we), .pal_a(pal_a), .pal_d(pal_d),
      .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .vblank(vblank)
   );

   always #20 clock = ~clock;

   function automatic logic [11:0] pal_def(input int idx);
      logic [7:0] v;
      v = 8'(idx);
      return {v[7:4], v[3:0], v[7:4] ^ v[3:0]};
   endfunction

   // Expected {rd, a, hs, vs, vblank, rgb} at the n-th displayed position after release.
   function automatic logic [33:0] model(input int cyc);
      int x, y, p, px, py, line;
      logic rd_e, hs_e, vs_e, vb_e;
      logic [17:0] a_e;
      logic [11:0] c_e;
      x = cyc % 800;
      y = (448 + cyc / 800) % 449;
      rd_e = (x < 320) && (y == 448 || (y < 398 && (y % 2) == 1));
      line = (y == 448) ? 0 : y / 2 + 1;
      a_e  = rd_e ? 18'(mpage * 65536 + 320 * line + x) : 18'd0;
      vb_e = (y >= 400);
      p = cyc - 2;
      if (p < 0) begin
         px = 0; py = 448;
      end else begin
         px = p % 800; py = (448 + p / 800) % 449;
      end
      hs_e = !(px >= 656 && px < 752);
      vs_e = (py >= 412 && py < 414);
      c_e  = (px < 640 && py < 400) ? mpal[mem[mpage * 65536 + 320 * (py / 2) + px / 2]] : 12'h000;
      return {rd_e, a_e, hs_e, vs_e, vb_e, c_e};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic goto(input int c);
      if (n > c) begin
         errors++;
         $display("FAIL goto: already at %0d, target %0d", n, c);
      end
      for (int k = 0; k < 10000 && n != c; k++) begin
         @(posedge clock); #1;
      end
      if (n != c) begin
         errors++;
         $display("FAIL goto_timeout: at %0d, target %0d", n, c);
      end
   endtask

   // Video memory: data for a strobed address is presented during the following clock.
   initial begin
      forever begin
         @(posedge clock); #1;
         i = mr_pv ? mem[mr_pa] : 8'h00;
         mr_pv = rd;
         mr_pa = a;
      end
   end

   // Whole-output comparison against the model on every post-release cycle.
   initial begin
      logic [33:0] exp_v, act_v;
      forever begin
         @(posedge clock); #2;
         if (chk_en) begin
            if (pw_vld && n == pw_n) begin
               mpal[pw_idx] = pw_val;
               pw_vld = 1'b0;
            end
            if (n == 0) mpage = int'(page);
            exp_v = model(n);
            act_v = {rd, exp_v[33] ? a : 18'd0, hs, vs, vblank, r, g, b};
            checks++;
            if (act_v !== exp_v) begin
               errors++;
               $display("FAIL cycle n=%0d: got %h, expected %h", n, act_v, exp_v);
            end
            n++;
         end
      end
   end

   initial begin
      for (int k = 0; k < 262144; k++) mem[k] = 8'((k * 13) ^ (k >> 9));
      mem[4] = 8'h11; mem[5] = 8'h2A; mem[6] = 8'h33; mem[7] = 8'h2A;
      mem[18'h10004] = 8'h11; mem[18'h10005] = 8'h2A; mem[18'h10007] = 8'h2A;

      repeat (3) @(posedge clock);
      #1;
      chk("reset_rd", 32'(rd), 32'd0);
      chk("reset_hs", 32'(hs), 32'd1);
      chk("reset_vs", 32'(vs), 32'd0);
      chk("reset_vblank", 32'(vblank), 32'd1);
      chk("reset_rgb", 32'({r, g, b}), 32'd0);

      for (int k = 0; k < 256; k++) begin
         @(posedge clock); #1;
         pal_we = 1'b1;
         pal_a  = 8'(k);
         pal_d  = (k == 8'h2A) ? 12'hF80 : pal_def(k);
         mpal[k] = pal_d;
      end
      @(posedge clock); #1;
      pal_we = 1'b0;

      // Run 1: page 0, pixel path and sync edges.
      repeat (3) @(posedge clock);
      #3;
      reset_n = 1'b1; n = 0; chk_en = 1'b1;
      @(posedge clock); #1;
      goto(0);
      chk("first_rd", 32'(rd), 32'd1);
      chk("first_addr", 32'(a), 32'h00000);
      goto(319);
      chk("last_addr", 32'(a), 32'h0013F);
      goto(320);
      chk("rd_end", 32'(rd), 32'd0);
      goto(657);  chk("hs_before", 32'(hs), 32'd1);
      goto(658);  chk("hs_fall", 32'(hs), 32'd0);
      goto(753);  chk("hs_last_low", 32'(hs), 32'd0);
      goto(754);  chk("hs_rise", 32'(hs), 32'd1);
      goto(799);  chk("vblank_hi", 32'(vblank), 32'd1);
      goto(800);  chk("vblank_lo", 32'(vblank), 32'd0);
      goto(811);  chk("pix_x9_y0", 32'({r, g, b}), 32'h110);
      goto(812);  chk("pix_x10_y0", 32'({r, g, b}), 32'hF80);
      goto(813);  chk("pix_x11_y0", 32'({r, g, b}), 32'hF80);
      goto(814);  chk("pix_x12_y0", 32'({r, g, b}), 32'h330);
      goto(1612); chk("pix_x10_y1", 32'({r, g, b}), 32'hF80);
      goto(1613); chk("pix_x11_y1", 32'({r, g, b}), 32'hF80);

      // Reset mid-line while fetching and displaying.
      goto(1700);
      chk_en = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("midreset_rd", 32'(rd), 32'd0);
      chk("midreset_hs", 32'(hs), 32'd1);
      chk("midreset_vs", 32'(vs), 32'd0);
      chk("midreset_vblank", 32'(vblank), 32'd1);
      chk("midreset_rgb", 32'({r, g, b}), 32'd0);
      page = 1'b1;
      repeat (5) @(posedge clock);
      #3;

      // Run 2: page 1 addressing, palette collision, mid-frame page change.
      reset_n = 1'b1; n = 0; chk_en = 1'b1;
      @(posedge clock); #1;
      goto(0);
      chk("p1_first_addr", 32'(a), 32'h10000);
      goto(811);
      pal_we = 1'b1; pal_a = 8'h2A; pal_d = 12'h00F;
      pw_idx = 8'h2A; pw_val = 12'h00F; pw_n = 813; pw_vld = 1'b1;
      goto(812);
      pal_we = 1'b0;
      chk("collide_old", 32'({r, g, b}), 32'hF80);
      goto(813);  chk("collide_new", 32'({r, g, b}), 32'h00F);
      goto(816);  chk("collide_later", 32'({r, g, b}), 32'h00F);
      goto(1600); chk("p1_line1_first", 32'(a), 32'h10140);
      goto(1919); chk("p1_line1_last", 32'(a), 32'h1027F);
      goto(1920); chk("p1_line1_end", 32'(rd), 32'd0);
      goto(2500);
      page = 1'b0;
      goto(3200);
      chk("flip_ignored_rd", 32'(rd), 32'd1);
      chk("flip_ignored_addr", 32'(a), 32'h10280);
      goto(3300);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
